// File: rtl/arm_mc_control.sv
// arm_mc_control: multicycle ARM control unit (main FSM, ALU decode, NZCV flags, condition gating)
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   Cond, Op, Funct, Rd instruction fields Instr[31:28], [27:26], [25:20], [15:12]
//   ALUFlags            NZCV produced by the ALU this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   architectural write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl   datapath selects
//   Flags               registered NZCV
//   State               current FSM state (debug)
module arm_mc_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         Cond,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic [3:0]         Rd,
   input  logic [3:0]         ALUFlags,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               AdrSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         RegSrc,
   output logic [1:0]         ALUControl,
   output logic [3:0]         Flags,
   output logic [STATE_W-1:0] State
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
      MEMWR = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
   } state_t;

   state_t     state, next;
   logic       ir_w, next_pc, reg_w, mem_w, branch, alu_op;
   logic       cond_ok, cond_ex;
   logic [1:0] flag_w;
   logic [3:0] cmd;
   logic       n, z, c, v;

   assign cmd = Funct[4:1];
   assign {n, z, c, v} = Flags;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         Flags   <= 4'b0000;
         cond_ex <= 1'b0;
      end else begin
         state <= next;
         // condition is frozen at decode so this instruction's own flag update cannot gate itself
         if (state == DECODE) cond_ex <= cond_ok;
         if ((state == EXECR || state == EXECI) && cond_ex) begin
            if (flag_w[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) Flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   always_comb begin
      next      = FETCH;
      ir_w      = 1'b0;
      next_pc   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      alu_op    = 1'b0;
      case (state)
         FETCH: begin
            next = DECODE; ir_w = 1'b1; next_pc = 1'b1;
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            next = (Op == 2'b00) ? (Funct[5] ? EXECI : EXECR) :
                   (Op == 2'b01) ? MEMADR :
                   (Op == 2'b10) ? BRANCH : FETCH;
         end
         MEMADR: begin ALUSrcB = 2'b01; next = Funct[0] ? MEMRD : MEMWR; end
         MEMRD:  begin AdrSrc = 1'b1; next = MEMWB; end
         MEMWB:  begin ResultSrc = 2'b01; reg_w = 1'b1; end
         MEMWR:  begin AdrSrc = 1'b1; mem_w = 1'b1; end
         EXECR:  begin alu_op = 1'b1; next = ALUWB; end
         EXECI:  begin ALUSrcB = 2'b01; alu_op = 1'b1; next = ALUWB; end
         ALUWB:  reg_w = 1'b1;
         BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      cond_ok = 1'b1;
      case (Cond)
         4'b0000: cond_ok = z;
         4'b0001: cond_ok = ~z;
         4'b0010: cond_ok = c;
         4'b0011: cond_ok = ~c;
         4'b0100: cond_ok = n;
         4'b0101: cond_ok = ~n;
         4'b0110: cond_ok = v;
         4'b0111: cond_ok = ~v;
         4'b1000: cond_ok = c & ~z;
         4'b1001: cond_ok = ~c | z;
         4'b1010: cond_ok = n == v;
         4'b1011: cond_ok = n != v;
         4'b1100: cond_ok = ~z & (n == v);
         4'b1101: cond_ok = z | (n != v);
         default: cond_ok = 1'b1;
      endcase
   end

   assign ALUControl = ~alu_op        ? 2'b00 :
                       cmd == 4'b0100 ? 2'b00 :
                       cmd == 4'b0010 ? 2'b01 :
                       cmd == 4'b0000 ? 2'b10 :
                       cmd == 4'b1100 ? 2'b11 : 2'b00;
   assign flag_w = {alu_op & Funct[0], alu_op & Funct[0] & (cmd == 4'b0100 || cmd == 4'b0010)};

   assign ImmSrc   = Op;
   assign RegSrc   = {Op == 2'b01, Op == 2'b10};
   assign State    = state;
   // write enables are held off for the whole reset pulse
   assign IRWrite  = ir_w & ~reset;
   assign PCWrite  = (next_pc | (cond_ex & (branch | (reg_w & Rd == 4'd15)))) & ~reset;
   assign RegWrite = reg_w & cond_ex & ~reset;
   assign MemWrite = mem_w & cond_ex & ~reset;
endmodule

// File: tb/tb_arm_mc_control.sv
// tb_arm_mc_control: table-driven, randomized and reset-sequence checks of arm_mc_control
module tb_arm_mc_control;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond, Rd, ALUFlags;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
   logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
   logic [3:0] Flags, State;
   logic [23:0] act;
   logic [3:0] mflags;
   int checks = 0, errors = 0;

   localparam logic [23:0] RST_MASK = 24'h0C0000;

   arm_mc_control dut (
      .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
      .Flags(Flags), .State(State)
   );

   always #5 clk = ~clk;

   assign act = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Flags};

   typedef struct {
      logic [3:0] cond;
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      logic [3:0] af;
      logic [3:0] flags_after;
   } vec_t;
   vec_t tbl[13];

   function automatic logic cond_holds(logic [3:0] cc, logic [3:0] f);
      logic n, z, c, v, base;
      {n, z, c, v} = f;
      case (cc[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & ~z;
         3'd5: base = n == v;
         3'd6: base = ~z & (n == v);
         default: return 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   function automatic logic [1:0] alu_of(logic [5:0] f);
      case (f[4:1])
         4'b0100: return 2'b00;
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [23:0] expect_vec(logic [3:0] st, logic ok, logic [1:0] op,
                                              logic [5:0] f, logic [3:0] rd, logic [3:0] fl);
      logic ir, npc, adr, sa, rw, mw, br, ex;
      logic [1:0] sb, rs;
      ir  = st == 0;
      npc = st == 0;
      adr = st == 3 || st == 5;
      sa  = st <= 1;
      sb  = (st <= 1) ? 2'b10 : (st == 2 || st == 7 || st == 9) ? 2'b01 : 2'b00;
      rs  = (st <= 1 || st == 9) ? 2'b10 : (st == 4) ? 2'b01 : 2'b00;
      rw  = st == 4 || st == 8;
      mw  = st == 5;
      br  = st == 9;
      ex  = st == 6 || st == 7;
      return {st, npc | (ok & (br | (rw & (rd == 4'd15)))), ir, rw & ok, mw & ok, adr, sa,
              sb, rs, op, op == 2'b01, op == 2'b10, ex ? alu_of(f) : 2'b00, fl};
   endfunction

   task automatic check(string name, logic [23:0] got, logic [23:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // one whole instruction from FETCH back to FETCH, inputs held steady as the IR would
   task automatic run_instr(logic [3:0] cc, logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                            logic [3:0] af, string tag);
      logic [3:0] seq[$];
      logic ok;
      Cond = cc; Op = op; Funct = f; Rd = rd; ALUFlags = af;
      #1;
      seq = {4'd0, 4'd1};
      if (op == 2'b00) begin
         seq.push_back(f[5] ? 4'd7 : 4'd6);
         seq.push_back(4'd8);
      end else if (op == 2'b01) begin
         seq.push_back(4'd2);
         if (f[0]) begin seq.push_back(4'd3); seq.push_back(4'd4); end
         else seq.push_back(4'd5);
      end else if (op == 2'b10) seq.push_back(4'd9);
      ok = cond_holds(cc, mflags);
      foreach (seq[i]) begin
         check(tag, act, expect_vec(seq[i], ok, op, f, rd, mflags));
         if ((seq[i] == 6 || seq[i] == 7) && ok && f[0]) begin
            mflags[3:2] = af[3:2];
            if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) mflags[1:0] = af[1:0];
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      tbl[0]  = '{4'b0000, 2'b01, 6'b011000, 4'd0,  4'b0000, 4'b0000}; // STR, EQ fails
      tbl[1]  = '{4'b1110, 2'b00, 6'b001001, 4'd1,  4'b0110, 4'b0110}; // ADDS R1
      tbl[2]  = '{4'b1110, 2'b01, 6'b011001, 4'd2,  4'b1111, 4'b0110}; // LDR
      tbl[3]  = '{4'b1110, 2'b00, 6'b000101, 4'd3,  4'b1000, 4'b1000}; // SUBS
      tbl[4]  = '{4'b1011, 2'b10, 6'b100000, 4'd0,  4'b0000, 4'b1000}; // BLT taken
      tbl[5]  = '{4'b1110, 2'b00, 6'b100001, 4'd4,  4'b0111, 4'b0100}; // ANDS imm, C/V kept
      tbl[6]  = '{4'b0001, 2'b00, 6'b001001, 4'd5,  4'b1111, 4'b0100}; // ADDSNE skipped
      tbl[7]  = '{4'b1110, 2'b00, 6'b000100, 4'd15, 4'b1111, 4'b0100}; // SUB PC
      tbl[8]  = '{4'b1110, 2'b11, 6'b000000, 4'd0,  4'b1111, 4'b0100}; // undefined
      tbl[9]  = '{4'b1110, 2'b00, 6'b011001, 4'd6,  4'b1010, 4'b1000}; // ORRS
      tbl[10] = '{4'b1110, 2'b00, 6'b001001, 4'd7,  4'b0000, 4'b0000}; // ADDS -> 0000
      tbl[11] = '{4'b1011, 2'b10, 6'b100000, 4'd0,  4'b1111, 4'b0000}; // BLT not taken
      tbl[12] = '{4'b1111, 2'b00, 6'b010101, 4'd8,  4'b1111, 4'b1100}; // other cmd, NZ only

      reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
      mflags = 4'b0000;
      #12;
      check("reset", act, expect_vec(4'd0, 1'b0, Op, Funct, Rd, 4'b0000) & ~RST_MASK);
      @(posedge clk); #1;
      check("reset_hold", act, expect_vec(4'd0, 1'b0, Op, Funct, Rd, 4'b0000) & ~RST_MASK);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_instr(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].af, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d_flags", i), {20'd0, Flags}, {20'd0, tbl[i].flags_after});
      end

      for (int i = 0; i < 150; i++)
         run_instr(4'($urandom), 2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
                   4'($urandom), $sformatf("rnd%0d", i));

      // asynchronous reset while in EXECR
      run_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110, "pre_rst");
      Cond = 4'b1110; Op = 2'b00; Funct = 6'b001001; Rd = 4'd1; ALUFlags = 4'b1111;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("in_execr", {20'd0, State}, 24'd6);
      #2 reset = 1'b1;
      #1;
      check("rst_execr", act, expect_vec(4'd0, 1'b0, Op, Funct, Rd, 4'b0000) & ~RST_MASK);
      @(posedge clk); #1;
      check("rst_execr_hold", act, expect_vec(4'd0, 1'b0, Op, Funct, Rd, 4'b0000) & ~RST_MASK);
      reset = 1'b0;
      mflags = 4'b0000;
      run_instr(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b1001, "post_rst");
      check("post_rst_flags", {20'd0, Flags}, 24'h000009);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
